// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Largest legal count for a given modulus: min(val, mod-1).
    function automatic logic [31:0] clamp_mod(input logic [31:0] val, input logic [31:0] mod);
        return (val >= mod) ? (mod - 32'd1) : val;
    endfunction

endpackage

// File: rtl/counter_next_state.sv
// Combinational next-count logic: step up or down by one, wrapping or
// holding at the bounds. Math is one bit wider than the count so that a
// full-range modulus (2**WIDTH) cannot overflow silently.
module counter_next_state
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    input  logic             mode,
    output logic [WIDTH-1:0] q_next,
    output logic             at_bound,
    output logic             wrapped
);

    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

    logic [WIDTH:0] w_q_ext;
    logic [WIDTH:0] w_sum;
    logic           w_unused_msb;

    assign w_q_ext = {1'b0, q};

    // Select the stepped value or the bound behaviour for the current direction.
    always_comb begin
        at_bound = 1'b0;
        wrapped  = 1'b0;
        w_sum    = w_q_ext;
        if (up_dn == DIR_UP) begin
            if (w_q_ext == MAX_EXT) begin
                at_bound = 1'b1;
                if (mode == MODE_WRAP) begin
                    w_sum   = '0;
                    wrapped = 1'b1;
                end
            end else begin
                w_sum = w_q_ext + ONE_EXT;
            end
        end else begin
            if (w_q_ext == '0) begin
                at_bound = 1'b1;
                if (mode == MODE_WRAP) begin
                    w_sum   = MAX_EXT;
                    wrapped = 1'b1;
                end
            end else begin
                w_sum = w_q_ext - ONE_EXT;
            end
        end
    end

    // The bound cases never leave a carry in the top bit, so it is dropped.
    assign q_next       = w_sum[WIDTH-1:0];
    assign w_unused_msb = w_sum[WIDTH];

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised synchronous up/down counter with programmable modulus,
// clamped parallel load, wrap or saturate mode, combinational terminal
// count (for cascading into the next stage's enable) and a registered
// wrap pulse.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0,
    parameter int RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap_p
);

    if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
        $error("updown_counter_mod: WIDTH=%0d out of range", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("updown_counter_mod: MODULUS=%0d illegal for WIDTH=%0d", MODULUS, WIDTH);
    end
    if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
        $error("updown_counter_mod: SATURATE=%0d must be 0 or 1", SATURATE);
    end
    if (RST_VAL < 0 || RST_VAL >= MODULUS) begin : g_bad_rst_val
        $error("updown_counter_mod: RST_VAL=%0d must be below MODULUS=%0d", RST_VAL, MODULUS);
    end

    localparam logic       MODE      = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap_p;
    logic [WIDTH-1:0] w_q_next;
    logic             w_at_bound;
    logic             w_wrapped;
    logic [WIDTH-1:0] w_load_q;

    counter_next_state #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q        (r_q),
        .up_dn    (up_dn),
        .mode     (MODE),
        .q_next   (w_q_next),
        .at_bound (w_at_bound),
        .wrapped  (w_wrapped)
    );

    assign w_load_q = WIDTH'(clamp_mod(32'(load_val), 32'(MODULUS)));

    // Count register with priority reset > load > enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= RST_Q;
            r_wrap_p <= 1'b0;
        end else if (load) begin
            r_q      <= w_load_q;
            r_wrap_p <= 1'b0;
        end else if (en) begin
            r_q      <= w_q_next;
            r_wrap_p <= w_wrapped;
        end else begin
            r_wrap_p <= 1'b0;
        end
    end

    // Terminal count is the same in wrap and saturate mode; held low during reset.
    assign tc     = en & ~load & ~rst & w_at_bound;
    assign q      = r_q;
    assign wrap_p = r_wrap_p;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed testbench for updown_counter_mod: default down-count, modulus-10
// up-count, saturating mode, load priority and clamping, reset priority,
// reset glitch immunity and a two-stage decimal cascade.
module tb_updown_counter_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // default instance: WIDTH 4, MODULUS 16, wrap, RST_VAL 0
    logic       def_rst = 1'b1, def_en = 1'b0, def_ud = 1'b0, def_ld = 1'b0;
    logic [3:0] def_lv = '0, def_q;
    logic       def_tc, def_w;

    // modulus 10 wrap instance
    logic       m10_rst = 1'b1, m10_en = 1'b0, m10_ud = 1'b1, m10_ld = 1'b0;
    logic [3:0] m10_lv = '0, m10_q;
    logic       m10_tc, m10_w;

    // saturating instance with non-zero reset value
    logic       sat_rst = 1'b1, sat_en = 1'b0, sat_ud = 1'b0, sat_ld = 1'b0;
    logic [3:0] sat_lv = '0, sat_q;
    logic       sat_tc, sat_w;

    // cascaded decimal pair
    logic       cas_rst = 1'b1, cas_en = 1'b0;
    logic [3:0] c0_q, c1_q;
    logic       c0_tc, c1_tc, c0_w, c1_w;

    updown_counter_mod u_def (
        .clk(clk), .rst(def_rst), .en(def_en), .up_dn(def_ud), .load(def_ld),
        .load_val(def_lv), .q(def_q), .tc(def_tc), .wrap_p(def_w)
    );

    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RST_VAL(0)) u_m10 (
        .clk(clk), .rst(m10_rst), .en(m10_en), .up_dn(m10_ud), .load(m10_ld),
        .load_val(m10_lv), .q(m10_q), .tc(m10_tc), .wrap_p(m10_w)
    );

    updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1), .RST_VAL(5)) u_sat (
        .clk(clk), .rst(sat_rst), .en(sat_en), .up_dn(sat_ud), .load(sat_ld),
        .load_val(sat_lv), .q(sat_q), .tc(sat_tc), .wrap_p(sat_w)
    );

    updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_c0 (
        .clk(clk), .rst(cas_rst), .en(cas_en), .up_dn(1'b1), .load(1'b0),
        .load_val(4'd0), .q(c0_q), .tc(c0_tc), .wrap_p(c0_w)
    );

    updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_c1 (
        .clk(clk), .rst(cas_rst), .en(c0_tc), .up_dn(1'b1), .load(1'b0),
        .load_val(4'd0), .q(c1_q), .tc(c1_tc), .wrap_p(c1_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int prev;
        int expq;
        int e3 [4] = '{1, 0, 0, 0};

        // ---- reset all instances; test 1 stimulus en=1, down ----
        def_en = 1'b1;
        def_ud = 1'b0;
        tick();
        chk("rst_def_q", 32'(def_q), 0);
        chk("rst_def_w", 32'(def_w), 0);
        chk("rst_m10_q", 32'(m10_q), 0);
        chk("rst_sat_q", 32'(sat_q), 5);
        chk("rst_sat_w", 32'(sat_w), 0);
        chk("tc_gated_by_rst", 32'(def_tc), 0);
        def_rst = 1'b0;
        #1;
        chk("tc_down_at_0", 32'(def_tc), 1);

        // ---- test 1: default down count 0,15,...,0,15 ----
        expq = 0;
        for (int i = 0; i < 17; i++) begin
            prev = expq;
            tick();
            expq = (prev == 0) ? 15 : prev - 1;
            chk("t1_q", 32'(def_q), 32'(expq));
            chk("t1_wrap", 32'(def_w), (prev == 0) ? 1 : 0);
            chk("t1_tc", 32'(def_tc), (expq == 0) ? 1 : 0);
        end

        // ---- test 4: load priority over enable, full-range wrap ----
        def_ld = 1'b1;
        def_lv = 4'd7;
        def_ud = 1'b1;
        #1;
        chk("t4_tc_gated_by_load", 32'(def_tc), 0);
        tick();
        chk("t4_load7", 32'(def_q), 7);
        chk("t4_load7_w", 32'(def_w), 0);
        def_lv = 4'd15;
        tick();
        chk("t4_load15", 32'(def_q), 15);
        def_ld = 1'b0;
        #1;
        chk("t4_tc_up_15", 32'(def_tc), 1);
        tick();
        chk("t4_full_wrap_q", 32'(def_q), 0);
        chk("t4_full_wrap_w", 32'(def_w), 1);

        // ---- test 5a: reset beats load and enable, clears wrap pulse ----
        def_ud = 1'b0;
        tick();
        chk("t5_pre_q", 32'(def_q), 15);
        chk("t5_pre_w", 32'(def_w), 1);
        def_rst = 1'b1;
        def_ld  = 1'b1;
        def_lv  = 4'd7;
        tick();
        chk("t5_rst_q", 32'(def_q), 0);
        chk("t5_rst_w", 32'(def_w), 0);
        def_rst = 1'b0;
        def_ld  = 1'b0;
        def_en  = 1'b0;

        // ---- test 2: modulus 10 up count ----
        m10_rst = 1'b0;
        m10_en  = 1'b1;
        m10_ud  = 1'b1;
        #1;
        chk("t2_tc_at_0", 32'(m10_tc), 0);
        expq = 0;
        for (int i = 0; i < 11; i++) begin
            prev = expq;
            tick();
            expq = (prev == 9) ? 0 : prev + 1;
            chk("t2_q", 32'(m10_q), 32'(expq));
            chk("t2_wrap", 32'(m10_w), (prev == 9) ? 1 : 0);
            chk("t2_tc", 32'(m10_tc), (expq == 9) ? 1 : 0);
        end
        m10_ld = 1'b1;
        m10_lv = 4'd12;
        tick();
        chk("t4_clamp_12", 32'(m10_q), 9);
        m10_ld = 1'b0;
        m10_en = 1'b0;
        tick();
        chk("t2_hold_en0", 32'(m10_q), 9);
        chk("t2_hold_w", 32'(m10_w), 0);

        // ---- test 3: saturating down, then reversal ----
        sat_rst = 1'b0;
        sat_ld  = 1'b1;
        sat_lv  = 4'd2;
        sat_en  = 1'b1;
        sat_ud  = 1'b0;
        tick();
        chk("t3_load2", 32'(sat_q), 2);
        sat_ld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_q", 32'(sat_q), 32'(e3[i]));
            chk("t3_tc", 32'(sat_tc), (e3[i] == 0) ? 1 : 0);
            chk("t3_wrap", 32'(sat_w), 0);
        end
        sat_ud = 1'b1;
        #1;
        chk("t3_tc_reversed", 32'(sat_tc), 0);
        tick();
        chk("t3_reverse_q", 32'(sat_q), 1);
        sat_ld = 1'b1;
        sat_lv = 4'd15;
        tick();
        sat_ld = 1'b0;
        #1;
        chk("t3_tc_top", 32'(sat_tc), 1);
        tick();
        chk("t3_sat_top_q", 32'(sat_q), 15);
        chk("t3_sat_top_w", 32'(sat_w), 0);

        // ---- test 5b: reset with load on saturating instance, then glitch ----
        sat_rst = 1'b1;
        sat_ld  = 1'b1;
        sat_lv  = 4'd9;
        tick();
        chk("t5_sat_rst_q", 32'(sat_q), 5);
        chk("t5_sat_rst_w", 32'(sat_w), 0);
        sat_rst = 1'b0;
        sat_ld  = 1'b0;
        sat_en  = 1'b0;
        #2;
        sat_rst = 1'b1;
        #2;
        sat_rst = 1'b0;
        sat_ld  = 1'b1;
        sat_lv  = 4'd11;
        #2;
        sat_ld  = 1'b0;
        tick();
        chk("t5_glitch_q", 32'(sat_q), 5);

        // ---- test 6: cascaded decimal counter ----
        tick();
        cas_rst = 1'b0;
        cas_en  = 1'b1;
        #1;
        chk("t6_start", 32'(int'(c1_q) * 10 + int'(c0_q)), 0);
        for (int i = 1; i <= 137; i++) begin
            tick();
            chk("t6_count", 32'(int'(c1_q) * 10 + int'(c0_q)), 32'(i % 100));
        end
        chk("t6_c1_wrap_gone", 32'(c1_w), 0);
        cas_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold", 32'(int'(c1_q) * 10 + int'(c0_q)), 37);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
